uart_tx_prescaled: RTL and testbench



---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_tx_prescaled_baud.sv | 35 +++
 rtl/uart_tx_prescaled.sv | 128 ++++++++++++
 tb/tb_uart_tx_prescaled.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud selects, divisors, FSM states.
// Used by the transmitter and the companion receiver.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int DIV_W = 15;

  localparam logic [1:0] BAUD_2400   = 2'b00;
  localparam logic [1:0] BAUD_9600   = 2'b01;
  localparam logic [1:0] BAUD_57600  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  localparam logic [DIV_W-1:0] DIV_2400   = 15'(DEF_CLK_FREQ / 2400);
  localparam logic [DIV_W-1:0] DIV_9600   = 15'(DEF_CLK_FREQ / 9600);
  localparam logic [DIV_W-1:0] DIV_57600  = 15'(DEF_CLK_FREQ / 57600);
  localparam logic [DIV_W-1:0] DIV_115200 = 15'(DEF_CLK_FREQ / 115200);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } uart_state_e;

  function automatic logic [DIV_W-1:0] baud_div(
    input logic [1:0]  sel,
    input int unsigned clk_freq
  );
    int unsigned d;
    d = clk_freq / 115200;
    unique case (sel)
      BAUD_2400:   d = clk_freq / 2400;
      BAUD_9600:   d = clk_freq / 9600;
      BAUD_57600:  d = clk_freq / 57600;
      BAUD_115200: d = clk_freq / 115200;
    endcase
    return d[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_prescaled_baud.sv
// Baud-rate tick generator: counts 0..div-1, ticks on the last count.
// Held at zero while clear is high so each frame starts a fresh period.
module baud_tick_gen
  import uart_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = !clear && (cnt_q == div - 15'd1);

  // next count: hold at zero on clear, wrap on tick
  always_comb begin
    cnt_d = cnt_q + 15'd1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_prescaled.sv
// 8N1 UART transmitter with per-frame latched baud prescaler.
// Outputs are registered one cycle behind the frame state.
module uart_tx_prescaled
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic [1:0] baudrate_sel,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [DIV_W-1:0] DIV0 = baud_div(BAUD_2400, CLK_FREQ);
  localparam logic [DIV_W-1:0] DIV1 = baud_div(BAUD_9600, CLK_FREQ);
  localparam logic [DIV_W-1:0] DIV2 = baud_div(BAUD_57600, CLK_FREQ);
  localparam logic [DIV_W-1:0] DIV3 = baud_div(BAUD_115200, CLK_FREQ);

  uart_state_e      state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] sel_div;
  logic             tick;

  baud_tick_gen u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_q == ST_IDLE),
    .div     (div_q),
    .tick    (tick)
  );

  // divisor for the currently selected rate
  always_comb begin
    sel_div = DIV3;
    unique case (baudrate_sel)
      BAUD_2400:   sel_div = DIV0;
      BAUD_9600:   sel_div = DIV1;
      BAUD_57600:  sel_div = DIV2;
      BAUD_115200: sel_div = DIV3;
    endcase
  end

  // frame sequencing: start, eight data bits LSB first, stop
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    div_d   = div_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shift_d = tx_data;
          div_d   = sel_div;
          idx_d   = 3'd0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // output values derived from the current frame state
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      ST_IDLE,
      ST_STOP:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != ST_IDLE);
    done_d = (state_q == ST_IDLE) && busy_q;
  end

  // state and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_prescaled.sv
// Bench for uart_tx_prescaled: output edges are logged as events
// and compared with events derived from the frame definition.
module tb_uart_tx_prescaled;

  localparam int D9600 = 50_000_000 / 9600;
  localparam int D115K = 50_000_000 / 115200;
  localparam int NOCUT = 32'h7fff_ffff;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [1:0] baudrate_sel;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  int  got_q[$];
  int  exp_q[$];
  bit  mon_en = 1'b0;
  logic tx_l, busy_l, done_l;

  uart_tx_prescaled #(.CLK_FREQ(50_000_000)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .baudrate_sel (baudrate_sel),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // event codes: 0 tx fell, 1 tx rose, 2 busy fell, 3 busy rose,
  // 4 done fell, 5 done rose; event = cycle*8 + code
  always @(negedge clock) begin
    if (mon_en) begin
      if (tx !== tx_l) got_q.push_back(cyc * 8 + (tx ? 1 : 0));
      if (tx_busy !== busy_l) got_q.push_back(cyc * 8 + (tx_busy ? 3 : 2));
      if (tx_done !== done_l) got_q.push_back(cyc * 8 + (tx_done ? 5 : 4));
      tx_l   = tx;
      busy_l = tx_busy;
      done_l = tx_done;
    end
  end

  // reference: frame accepted at edge k, line lags one edge, each
  // of the ten bits lasts div clocks; events at or after cut dropped
  function automatic void add_frame(input logic [7:0] d, input int div,
                                    input int k, input int cut);
    logic [9:0] bits;
    logic       prev;
    int         t;
    bits = {1'b1, d, 1'b0};
    prev = 1'b1;
    for (int i = 0; i < 10; i++) begin
      t = k + 1 + i * div;
      if (bits[i] != prev && t < cut) exp_q.push_back(t * 8 + (bits[i] ? 1 : 0));
      prev = bits[i];
    end
    t = k + 1 + 10 * div;
    if (k + 1 < cut) exp_q.push_back((k + 1) * 8 + 3);
    if (t < cut) begin
      exp_q.push_back(t * 8 + 2);
      exp_q.push_back(t * 8 + 5);
      exp_q.push_back((t + 1) * 8 + 4);
    end
  endfunction

  task automatic start_mon();
    got_q.delete();
    exp_q.delete();
    tx_l   = tx;
    busy_l = tx_busy;
    done_l = tx_done;
    mon_en = 1'b1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int k, n, g, e;
    reset_n = 1'b0;
    tx_start = 1'b1;
    baudrate_sel = 2'b11;
    d = 8'($urandom);
    tx_data = d;
    repeat (4) begin
      @(negedge clock);
      chk++;
      if ({tx, tx_busy, tx_done} !== 3'b100) begin
        err++;
        $display("FAIL reset_hold tx/busy/done=%b exp=100", {tx, tx_busy, tx_done});
      end
    end
    start_mon();
    reset_n = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    tx_start = 1'b0;
    add_frame(d, D115K, k, NOCUT);
    wait_until(k + 10 * D115K + 10);
    got_q.sort();
    exp_q.sort();
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? got_q[i] : -8;
      e = (i < exp_q.size()) ? exp_q[i] : -8;
      chk++;
      if (g !== e) begin
        err++;
        $display("FAIL reset_first ev%0d got cyc=%0d code=%0d exp cyc=%0d code=%0d",
                 i, g / 8, g % 8, e / 8, e % 8);
      end
    end
  endtask

  task automatic test_single_frame();
    int k, n, g, e;
    start_mon();
    @(negedge clock);
    tx_data = 8'h30;
    baudrate_sel = 2'b01;
    tx_start = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    tx_start = 1'b0;
    add_frame(8'h30, D9600, k, NOCUT);
    wait_until(k + 10 * D9600 + 10);
    got_q.sort();
    exp_q.sort();
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? got_q[i] : -8;
      e = (i < exp_q.size()) ? exp_q[i] : -8;
      chk++;
      if (g !== e) begin
        err++;
        $display("FAIL single ev%0d got cyc=%0d code=%0d exp cyc=%0d code=%0d",
                 i, g / 8, g % 8, e / 8, e % 8);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k1, k2, n, g, e;
    start_mon();
    @(negedge clock);
    tx_data = 8'h55;
    baudrate_sel = 2'b11;
    tx_start = 1'b1;
    k1 = cyc + 1;
    k2 = k1 + 1 + 10 * D115K;
    wait_until(k2);
    tx_start = 1'b0;
    add_frame(8'h55, D115K, k1, NOCUT);
    add_frame(8'h55, D115K, k2, NOCUT);
    wait_until(k2 + 10 * D115K + 10);
    got_q.sort();
    exp_q.sort();
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? got_q[i] : -8;
      e = (i < exp_q.size()) ? exp_q[i] : -8;
      chk++;
      if (g !== e) begin
        err++;
        $display("FAIL b2b ev%0d got cyc=%0d code=%0d exp cyc=%0d code=%0d",
                 i, g / 8, g % 8, e / 8, e % 8);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    logic [7:0] d;
    int k, n, g, e;
    start_mon();
    d = 8'($urandom);
    @(negedge clock);
    tx_data = d;
    baudrate_sel = 2'b11;
    tx_start = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    tx_start = 1'b0;
    wait_until(k + 500 + int'($urandom_range(0, 3000)));
    tx_data = 8'hFF;
    baudrate_sel = 2'b10;
    add_frame(d, D115K, k, NOCUT);
    wait_until(k + 10 * D115K + 10);
    got_q.sort();
    exp_q.sort();
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? got_q[i] : -8;
      e = (i < exp_q.size()) ? exp_q[i] : -8;
      chk++;
      if (g !== e) begin
        err++;
        $display("FAIL midchange ev%0d got cyc=%0d code=%0d exp cyc=%0d code=%0d",
                 i, g / 8, g % 8, e / 8, e % 8);
      end
    end
  endtask

  task automatic test_ignore_busy_start();
    logic [7:0] d;
    int k, n, g, e;
    int pc[3];
    start_mon();
    d = 8'($urandom);
    @(negedge clock);
    tx_data = d;
    baudrate_sel = 2'b11;
    tx_start = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    tx_start = 1'b0;
    pc[0] = k + 1 + int'($urandom_range(0, 4 * D115K));
    pc[1] = k + 5 * D115K + int'($urandom_range(0, 4 * D115K));
    pc[2] = k + 10 * D115K - 1;
    for (int p = 0; p < 3; p++) begin
      wait_until(pc[p]);
      tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0;
    end
    add_frame(d, D115K, k, NOCUT);
    wait_until(k + 10 * D115K + 600);
    got_q.sort();
    exp_q.sort();
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? got_q[i] : -8;
      e = (i < exp_q.size()) ? exp_q[i] : -8;
      chk++;
      if (g !== e) begin
        err++;
        $display("FAIL busy_ignore ev%0d got cyc=%0d code=%0d exp cyc=%0d code=%0d",
                 i, g / 8, g % 8, e / 8, e % 8);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d, d2;
    int k, k2, r, n, g, e;
    start_mon();
    d = 8'($urandom);
    d2 = 8'($urandom);
    @(negedge clock);
    tx_data = d;
    baudrate_sel = 2'b11;
    tx_start = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    tx_start = 1'b0;
    wait_until(k + 1 + 4 * D115K + int'($urandom_range(50, 380)));
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    r = cyc;
    #1;
    chk++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      err++;
      $display("FAIL async_abort tx/busy/done=%b exp=100", {tx, tx_busy, tx_done});
    end
    add_frame(d, D115K, k, r);
    exp_q.push_back(r * 8 + 2);
    if (!d[3]) exp_q.push_back(r * 8 + 1);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    tx_data = d2;
    tx_start = 1'b1;
    k2 = cyc + 1;
    @(negedge clock);
    tx_start = 1'b0;
    add_frame(d2, D115K, k2, NOCUT);
    wait_until(k2 + 10 * D115K + 10);
    got_q.sort();
    exp_q.sort();
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? got_q[i] : -8;
      e = (i < exp_q.size()) ? exp_q[i] : -8;
      chk++;
      if (g !== e) begin
        err++;
        $display("FAIL reset_mid ev%0d got cyc=%0d code=%0d exp cyc=%0d code=%0d",
                 i, g / 8, g % 8, e / 8, e % 8);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    tx_start = 1'b0;
    tx_data = 8'h00;
    baudrate_sel = 2'b00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_mid_frame_change();
    test_ignore_busy_start();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
